// File: rtl/prog_sequencer_pkg.sv
// prog_seq_pkg: shared types and defaults for the program launch sequencer.
package prog_seq_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    typedef logic [1:0] prog_idx_t;
    localparam int START0_DEF = 0;
    localparam int START1_DEF = 256;
    localparam int START2_DEF = 512;
    function automatic prog_idx_t next_idx(prog_idx_t i, int n);
        return (int'(i) == n - 1) ? prog_idx_t'(0) : prog_idx_t'(i + 2'd1);
    endfunction
endpackage

// File: rtl/prog_sequencer_if.sv
// prog_sequencer_if: req/ack handshake and core fetch-control bundle.
// PROG_CYCLE_COUNT_EN adds cyc_count and the WDOG_W parameter sizing it.
interface prog_sequencer_if
    import prog_seq_pkg::*;
#(
    parameter int PC_W = 10
`ifdef PROG_CYCLE_COUNT_EN
    , parameter int WDOG_W = 16
`endif
);
    logic            req;
    logic            ack;
    logic            halt;
    logic            core_run;
    logic            pc_load;
    logic [PC_W-1:0] pc_start;
    prog_idx_t       prog_idx;
    logic            busy;
    logic            timeout_err;
`ifdef PROG_CYCLE_COUNT_EN
    logic [WDOG_W-1:0] cyc_count;
    modport master (input req, halt,
                    output ack, core_run, pc_load, pc_start, prog_idx, busy, timeout_err, cyc_count);
    modport slave  (output req, halt,
                    input ack, core_run, pc_load, pc_start, prog_idx, busy, timeout_err, cyc_count);
`else
    modport master (input req, halt,
                    output ack, core_run, pc_load, pc_start, prog_idx, busy, timeout_err);
    modport slave  (output req, halt,
                    input ack, core_run, pc_load, pc_start, prog_idx, busy, timeout_err);
`endif
endinterface

// File: rtl/prog_sequencer_watchdog.sv
// prog_watchdog: clearable RUN-cycle counter; tc flags the cycle whose increment reaches all-ones.
// count is exported only under PROG_CYCLE_COUNT_EN.
module prog_watchdog #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
`ifdef PROG_CYCLE_COUNT_EN
    output logic [W-1:0] count,
`endif
    output logic         tc
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge reset)
        if (!reset)   cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + 1'b1;
    assign tc = en && (cnt == {{(W-1){1'b1}}, 1'b0});
`ifdef PROG_CYCLE_COUNT_EN
    assign count = cnt;
`endif
endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: launches resident programs on req, stalls the core between them, aborts runaways.
// Optional PROG_CYCLE_COUNT_EN adds cyc_count (RUN cycles of the last completed program).
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int PC_W     = 10,
    parameter int NUM_PROG = 3,
    parameter int START0   = START0_DEF,
    parameter int START1   = START1_DEF,
    parameter int START2   = START2_DEF,
    parameter int WDOG_W   = 16
) (
    input logic              clk,
    input logic              reset,
    prog_sequencer_if.master bus
);
    state_t          state, state_nx;
    logic            req_q, launch, run_end, wd_tc;
    logic [PC_W-1:0] start_sel;
`ifdef PROG_CYCLE_COUNT_EN
    logic [WDOG_W-1:0] wd_count;
`endif
    assign launch    = (state == IDLE || state == DONE) && bus.req && !req_q;
    assign run_end   = state == RUN && (bus.halt || wd_tc);
    assign start_sel = bus.prog_idx == 2'd0 ? PC_W'(START0) :
                       bus.prog_idx == 2'd1 ? PC_W'(START1) : PC_W'(START2);
    prog_watchdog #(.W(WDOG_W)) u_wdog (
        .clk   (clk),
        .reset (reset),
        .clr   (state == LOAD),
        .en    (state == RUN),
`ifdef PROG_CYCLE_COUNT_EN
        .count (wd_count),
`endif
        .tc    (wd_tc)
    );
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    // ack/core_run/busy follow the state directly, so an async reset drops them at once
    always_comb begin
        state_nx     = launch ? LOAD : state == LOAD ? RUN : run_end ? DONE : state;
        bus.ack      = state == DONE;
        bus.core_run = state == RUN;
        bus.pc_load  = state == LOAD;
        bus.busy     = state == LOAD || state == RUN;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            req_q           <= 1'b0;
            bus.pc_start    <= PC_W'(START0);
            bus.prog_idx    <= '0;
            bus.timeout_err <= 1'b0;
`ifdef PROG_CYCLE_COUNT_EN
            bus.cyc_count   <= '0;
`endif
        end else begin
            req_q <= bus.req;
            if (launch) bus.pc_start <= start_sel;
            if (run_end) begin
                bus.prog_idx <= next_idx(bus.prog_idx, NUM_PROG);
                if (!bus.halt) bus.timeout_err <= 1'b1;
`ifdef PROG_CYCLE_COUNT_EN
                bus.cyc_count <= wd_count + 1'b1;
`endif
            end
        end
endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: directed plus randomized rounds checked against a program-level reference model.
// WDOG_W is shrunk to 6 so a runaway program aborts after 63 RUN cycles.
module tb_prog_sequencer;
    localparam int WD   = 6;
    localparam int TMAX = (1 << WD) - 1;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    prog_sequencer_if #(.PC_W(10)
`ifdef PROG_CYCLE_COUNT_EN
        , .WDOG_W(WD)
`endif
    ) bus ();
    prog_sequencer #(.WDOG_W(WD)) dut (.clk(clk), .reset(reset), .bus(bus.master));
    int vectors = 0;
    int errs    = 0;
    int starts [3] = '{0, 256, 512};
    int exp_idx = 0;
    int exp_cyc = 0;
    bit exp_to  = 1'b0;
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask
    task automatic chk_cyc(string tag);
`ifdef PROG_CYCLE_COUNT_EN
        chk(tag, 32'(bus.cyc_count), exp_cyc);
`else
        if (tag.len() == 0) $display("empty tag");
`endif
    endtask
    task automatic chk_rest(string tag, bit ack);
        chk({tag, ".ack"}, bus.ack, ack);
        chk({tag, ".core_run"}, bus.core_run, 0);
        chk({tag, ".pc_load"}, bus.pc_load, 0);
        chk({tag, ".busy"}, bus.busy, 0);
        chk({tag, ".prog_idx"}, bus.prog_idx, exp_idx);
        chk({tag, ".timeout_err"}, bus.timeout_err, exp_to);
        chk_cyc({tag, ".cyc_count"});
    endtask
    // one launch: req held `hold` cycles, halt in RUN cycle halt_at (out of range = runaway)
    task automatic round(int hold, int halt_at, bit spur, bit edge_done, bit ld_halt);
        bit in_range = halt_at >= 1 && halt_at <= TMAX;
        int end_k    = in_range ? halt_at : TMAX;
        int t;
        @(negedge clk);
        bus.req = 1'b1;
        @(negedge clk);
        t = 1;
        chk("load.pc_load", bus.pc_load, 1);
        chk("load.pc_start", bus.pc_start, starts[exp_idx]);
        chk("load.prog_idx", bus.prog_idx, exp_idx);
        chk("load.core_run", bus.core_run, 0);
        chk("load.busy", bus.busy, 1);
        chk("load.ack", bus.ack, 0);
        chk_cyc("load.cyc_count");
        bus.req  = t < hold;
        bus.halt = ld_halt;
        for (int k = 1; k <= end_k; k++) begin
            @(negedge clk);
            t = k + 1;
            chk("run.core_run", bus.core_run, 1);
            chk("run.pc_load", bus.pc_load, 0);
            chk("run.ack", bus.ack, 0);
            bus.halt = k == halt_at;
            bus.req  = (t < hold) || (spur && k == 3) || (edge_done && k == end_k);
        end
        @(negedge clk);
        bus.halt = 1'b0;
        exp_idx  = (exp_idx + 1) % 3;
        exp_to   = exp_to | !in_range;
        exp_cyc  = end_k;
        chk_rest("done", 1'b1);
        bus.req = 1'b0;
        repeat (2) @(negedge clk);
        chk_rest("done_hold", 1'b1);
    endtask
    initial begin
        bus.req  = 1'b0;
        bus.halt = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.pc_start", bus.pc_start, 0);
        chk_rest("reset", 1'b0);
        reset = 1'b1;
        round(1, 40, 0, 0, 0);
        round(5, 20, 1, 0, 1);
        round(1, 30, 1, 1, 0);
        round(1, 10, 0, 0, 0);
        round(1, 0, 0, 0, 0);
        round(2, 25, 0, 1, 0);
        @(negedge clk);
        bus.req = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        exp_idx = 0;
        exp_to  = 1'b0;
        exp_cyc = 0;
        chk("areset.pc_start", bus.pc_start, 0);
        chk_rest("areset", 1'b0);
        @(negedge clk);
        reset = 1'b1;
        round(1, TMAX, 0, 0, 0);
        round(1, TMAX - 1, 0, 0, 1);
        repeat (8) round(int'($urandom_range(1, 4)), int'($urandom_range(1, 70)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
Program launch controller sitting between the top-level req/ack handshake and the core's fetch unit. Each req pulse starts the next of NUM_PROG resident programs (Hamming encode, Hamming decode/correct, pattern count) at that program's start address. It stalls the core between programs and raises ack when the core halts. A watchdog aborts runaway programs.

Parameters:
PC_W, 10, instruction-address width
NUM_PROG, 3, number of resident programs, cycled 0..NUM_PROG-1
START0, 0, start PC of program 0
START1, 256, start PC of program 1
START2, 512, start PC of program 2
WDOG_W, 16, watchdog counter width; timeout after 2**WDOG_W-1 RUN cycles

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req  in  1  start-next-program request, level; sampled for rising edge
ack  out  1  program complete; held high until next accepted req
halt  in  1  core executed halt; valid only while core_run=1
core_run  out  1  core may fetch/execute; 0 = core stalled
pc_load  out  1  one-cycle strobe: core loads pc_start into PC
pc_start  out  PC_W  start address of the program being launched
prog_idx  out  2  index of current/last launched program
busy  out  1  1 in LOAD or RUN
timeout_err  out  1  sticky; set when watchdog aborts a program

Behaviour:
- Reset (reset=0, async): state=IDLE; ack=0, core_run=0, pc_load=0, pc_start=START0, prog_idx=0, busy=0, timeout_err=0, watchdog=0, req_q=0.
- Edge detect: req_q <= req every cycle; req_rise = req & ~req_q. A 1-cycle pulse is sufficient. A held-high req produces only one launch.
- States: IDLE, LOAD, RUN, DONE.
- IDLE/DONE + req_rise -> LOAD. On that edge: ack<=0, pc_start<=START[prog_idx], pc_load<=1, busy<=1.
- LOAD (exactly 1 cycle): pc_load=1, core_run=0; halt ignored -> RUN. On exit pc_load<=0, core_run<=1, watchdog<=0.
- RUN: watchdog increments each cycle.
  - halt=1 -> DONE.
  - Watchdog reaching all-ones without halt -> DONE with timeout_err<=1.
  - halt and timeout in the same cycle: halt wins, timeout_err unchanged.
- Entering DONE: core_run<=0, busy<=0, ack<=1, prog_idx<=(prog_idx==NUM_PROG-1)?0:prog_idx+1.
- Latency: req_rise at edge N -> pc_load high in cycle N+1 -> core_run high from N+2. Halt sampled at edge M -> ack high and core_run low from M+1.
- req_rise during LOAD or RUN: ignored, not queued.
- req_rise in the same cycle DONE is entered: ignored.
- ack stays 1 in DONE indefinitely; it drops only on the edge accepting the next req.
- timeout_err clears only on reset.
- Reset asserted mid-RUN: immediate return to reset values. The core is stalled, and the next req restarts at program 0.

Optional Feature:
PROG_CYCLE_COUNT_EN: when defined, adds output cyc_count[WDOG_W] holding the RUN-cycle count of the last completed program. It is latched on entry to DONE, holds until the next DONE, and resets to 0. When undefined, the port and its register are absent; behaviour is otherwise identical.

Decomposition:
- Package prog_seq_pkg: state enum typedef (IDLE, LOAD, RUN, DONE), program-index typedef, default start-address localparams.
- Sub-module prog_watchdog: clear, enable, count, terminal-count flag. Reused by the cycle-count option.

Test Plan:
- Reset then req pulse -> pc_load=1 for 1 cycle with pc_start=0, prog_idx=0; core_run=1 two cycles after req; halt after 40 cycles -> ack=1, core_run=0 next cycle, prog_idx=1.
- Three consecutive req/halt rounds -> pc_start sequence 0, 256, 512; fourth req wraps to 0 with prog_idx=0.
- req held high 5 cycles, then extra req pulse during RUN -> exactly one launch; ack=1 only after halt; no second pc_load.
- No halt, WDOG_W=4 -> DONE after 15 RUN cycles, timeout_err=1 sticky across next normal program; halt on cycle 15 -> timeout_err stays 0.
- reset=0 asserted mid-RUN -> core_run=0 and ack=0 asynchronously; next req launches START0.
- PROG_CYCLE_COUNT_EN defined, halt after 40 RUN cycles -> cyc_count=40 at ack, held through the next LOAD.
